mc_main_controller: RTL and testbench
=====================================

// Module: mc_main_controller
// PURPOSE
//  Main control FSM of the multi-cycle MIPS datapath. Decodes Opcode and sequences
//  fetch/decode/execute/memory/writeback, one state per clock. Drives every datapath
//  strobe and the 2-bit ALUOP consumed by the ALU controller.
//  ALUOP encoding: 00 add, 01 sub, 10 use funct, 11 slt.
// PARAMETERS
//  COUNT_W   32   width of retired-instruction counter InstrCount
// PORTS
//  clk          in   1        system clock, rising edge
//  rst          in   1        synchronous, active-high reset
//  Opcode       in   6        IR[31:26]
//  Zero         in   1        ALU zero flag
//  PCWrite      out  1        unconditional PC load
//  PCWriteCond  out  1        PC load qualified by Zero
//  PCEn         out  1        PCWrite | (PCWriteCond & Zero)
//  IorD         out  1        mem addr: 0 PC, 1 ALUOut
//  MemRead      out  1        memory read strobe
//  MemWrite     out  1        memory write strobe
//  IRWrite      out  1        IR load
//  RegDst       out  2        00 rt, 01 rd, 10 $31
//  MemtoReg     out  2        00 ALUOut, 01 MDR, 10 PC
//  RegWrite     out  1        register-file write
//  ALUSrcA      out  1        0 PC, 1 A
//  ALUSrcB      out  2        00 B, 01 const 4, 10 sext imm, 11 sext imm<<2
//  ALUOP        out  2        to ALU controller
//  PCSource     out  2        00 ALU result, 01 ALUOut, 10 jump target
//  Illegal      out  1        unrecognised opcode seen in DECODE
//  InstrCount   out  COUNT_W  instructions retired since reset
// BEHAVIOUR
//  - Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, slti 001010,
//    j 000010, jal 000011 (jal only with macro).
//  - Moore outputs decoded from state register; PCEn and Illegal also use Zero/Opcode.
//    Unlisted outputs are 0 in every state.
//  - States (4-bit) and transitions:
//    FETCH : MemRead IRWrite PCWrite, ALUSrcB=01, ALUOP=00, PCSource=00 -> DECODE
//    DECODE: ALUSrcB=11, ALUOP=00 -> by Opcode:
//            lw/sw MEMADR, R REXEC, beq BEQ, addi ADDIEX, slti SLTIEX, j JUMP,
//            jal JAL; other -> FETCH with Illegal=1 this cycle
//    MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOP=00 -> lw MEMRD, sw MEMWR
//    MEMRD : IorD MemRead -> MEMWB
//    MEMWB : RegDst=00, MemtoReg=01, RegWrite -> FETCH
//    MEMWR : IorD MemWrite -> FETCH
//    REXEC : ALUSrcA=1, ALUSrcB=00, ALUOP=10 -> RWB
//    RWB   : RegDst=01, MemtoReg=00, RegWrite -> FETCH
//    BEQ   : ALUSrcA=1, ALUSrcB=00, ALUOP=01, PCWriteCond, PCSource=01 -> FETCH
//    ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOP=00 -> IWB
//    SLTIEX: ALUSrcA=1, ALUSrcB=10, ALUOP=11 -> IWB
//    IWB   : RegDst=00, MemtoReg=00, RegWrite -> FETCH
//    JUMP  : PCWrite, PCSource=10 -> FETCH
//    JAL   : PCWrite, PCSource=10, RegWrite, RegDst=10, MemtoReg=10 -> FETCH
//    Unused encodings -> FETCH.
//  - Cycles per instruction, FETCH inclusive: lw 5; sw, R, addi, slti 4; beq, j, jal 3;
//    illegal 2.
//  - InstrCount +1 on every edge where state moves into FETCH from a non-FETCH state,
//    illegal path included. Wraps modulo 2^COUNT_W without saturating.
//  - Reset: rst=1 at an edge forces state=FETCH and InstrCount=0.
//    While rst=1, all strobes (PCWrite, PCWriteCond, PCEn, MemRead, MemWrite,
//    IRWrite, RegWrite) and Illegal are forced 0.
//    Mid-instruction reset abandons the instruction with no further strobes. The first
//    cycle after rst falls is FETCH.
// CONFIGURATION
//  - MC_JAL_EN defined: JAL state present, opcode 000011 decodes to JAL.
//  - MC_JAL_EN undefined: JAL state absent, 000011 is illegal. RegDst/MemtoReg keep
//    2-bit width, but never take value 10.
// TESTING
//  - rst held 3 cycles mid-MEMRD, then released -> FETCH next cycle, InstrCount=0,
//    no RegWrite/MemWrite pulse.
//  - lw 100011 -> FETCH,DECODE,MEMADR,MEMRD,MEMWB; RegWrite only in MEMWB with
//    MemtoReg=01; InstrCount +1.
//  - R 000000 -> ALUOP=10 only in REXEC. slti 001010 -> ALUOP=11 in SLTIEX.
//    Both write back in 4 cycles.
//  - beq with Zero=1 -> PCEn=1 in BEQ; beq with Zero=0 -> PCEn=0. Both back in
//    FETCH after 3 cycles.
//  - Opcode 111111 -> Illegal=1 in DECODE only, FETCH next, InstrCount +1, no strobes.
//  - 000011 with MC_JAL_EN -> JAL, RegDst=10, MemtoReg=10, RegWrite=1, PCWrite=1.
//    Without MC_JAL_EN -> Illegal=1.

Source files
------------

// File: rtl/mc_main_controller_if.sv
// Bus between the multi-cycle MIPS main controller and its datapath.
// The controller uses the master modport; the datapath side uses slave.
interface mc_main_controller_if #(
  parameter int COUNT_W = 32
);
  logic [5:0]         Opcode;
  logic               Zero;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               PCEn;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic [1:0]         RegDst;
  logic [1:0]         MemtoReg;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ALUOP;
  logic [1:0]         PCSource;
  logic               Illegal;
  logic [COUNT_W-1:0] InstrCount;

  modport master (
    input  Opcode, Zero,
    output PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOP, PCSource,
           Illegal, InstrCount
  );

  modport slave (
    output Opcode, Zero,
    input  PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOP, PCSource,
           Illegal, InstrCount
  );
endinterface

// File: rtl/mc_main_controller.sv
// Main control FSM of the multi-cycle MIPS datapath, plus a retired-instruction counter.
// Optional feature: define MC_JAL_EN to add the JAL state and decode opcode 000011.
module mc_main_controller #(
  parameter int COUNT_W = 32
) (
  input logic                clk,
  input logic                rst,
  mc_main_controller_if.master bus
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MC_JAL_EN
  localparam logic [5:0] OP_JAL  = 6'b000011;
`endif

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_SLTIEX = 4'd10,
    S_IWB    = 4'd11,
`ifdef MC_JAL_EN
    S_JAL    = 4'd13,
`endif
    S_JUMP   = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] memto_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  function automatic ctrl_t decode_state(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read = 1'b1; c.ir_write = 1'b1; c.pc_write = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEMRD:  begin c.iord = 1'b1; c.mem_read = 1'b1; end
      S_MEMWB:  begin c.memto_reg = 2'b01; c.reg_write = 1'b1; end
      S_MEMWR:  begin c.iord = 1'b1; c.mem_write = 1'b1; end
      S_REXEC:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      S_RWB:    begin c.reg_dst = 2'b01; c.reg_write = 1'b1; end
      S_BEQ: begin
        c.alu_src_a = 1'b1; c.alu_op = 2'b01;
        c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
      end
      S_ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_SLTIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 2'b11; end
      S_IWB:    c.reg_write = 1'b1;
      S_JUMP:   begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
`ifdef MC_JAL_EN
      S_JAL: begin
        c.pc_write = 1'b1; c.pc_source = 2'b10; c.reg_write = 1'b1;
        c.reg_dst = 2'b10; c.memto_reg = 2'b10;
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t             state_q, state_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               op_legal;
  logic               retire;

  always_comb begin
    state_d  = S_FETCH;
    op_legal = 1'b1;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_REXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_SLTI:      state_d = S_SLTIEX;
          OP_J:         state_d = S_JUMP;
`ifdef MC_JAL_EN
          OP_JAL:       state_d = S_JAL;
`endif
          default: begin
            state_d  = S_FETCH;
            op_legal = 1'b0;
          end
        endcase
      end
      S_MEMADR: state_d = (bus.Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_REXEC:  state_d = S_RWB;
      S_ADDIEX: state_d = S_IWB;
      S_SLTIEX: state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase
    // An instruction retires whenever the FSM re-enters FETCH, illegal path included.
    retire  = (state_d == S_FETCH) && (state_q != S_FETCH);
    count_d = count_q + {{(COUNT_W-1){1'b0}}, retire};
    ctrl_d  = decode_state(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ctrl_q  <= decode_state(S_FETCH);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
    end
  end

  // Strobes are masked while reset is asserted so an abandoned instruction has no side effects.
  assign bus.PCWrite     = ctrl_q.pc_write & ~rst;
  assign bus.PCWriteCond = ctrl_q.pc_write_cond & ~rst;
  assign bus.PCEn        = (ctrl_q.pc_write | (ctrl_q.pc_write_cond & bus.Zero)) & ~rst;
  assign bus.IorD        = ctrl_q.iord;
  assign bus.MemRead     = ctrl_q.mem_read & ~rst;
  assign bus.MemWrite    = ctrl_q.mem_write & ~rst;
  assign bus.IRWrite     = ctrl_q.ir_write & ~rst;
  assign bus.RegDst      = ctrl_q.reg_dst;
  assign bus.MemtoReg    = ctrl_q.memto_reg;
  assign bus.RegWrite    = ctrl_q.reg_write & ~rst;
  assign bus.ALUSrcA     = ctrl_q.alu_src_a;
  assign bus.ALUSrcB     = ctrl_q.alu_src_b;
  assign bus.ALUOP       = ctrl_q.alu_op;
  assign bus.PCSource    = ctrl_q.pc_source;
  assign bus.Illegal     = (state_q == S_DECODE) & ~op_legal & ~rst;
  assign bus.InstrCount  = count_q;

endmodule

// File: tb/tb_mc_main_controller.sv
// Scoreboard bench for mc_main_controller: expected per-cycle control vectors are queued
// as each instruction is issued and compared cycle by cycle. Honours MC_JAL_EN.
module tb_mc_main_controller;

  localparam int COUNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_main_controller_if #(.COUNT_W(COUNT_W)) bus ();

  mc_main_controller #(.COUNT_W(COUNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    string       tag;
    logic [19:0] vec;
    int          cnt;
  } entry_t;

  entry_t sb_q[$];
  int     errors = 0;
  int     checks = 0;
  int     exp_count = 0;

  // Field order: PCWrite PCWriteCond PCEn IorD MemRead MemWrite IRWrite RegDst MemtoReg
  // RegWrite ALUSrcA ALUSrcB ALUOP PCSource Illegal.
  function automatic logic [19:0] mk(
    input logic pcw, input logic pcwc, input logic pcen, input logic iord,
    input logic mr, input logic mw, input logic irw, input logic [1:0] rd,
    input logic [1:0] mtr, input logic rw, input logic asa, input logic [1:0] asb,
    input logic [1:0] aop, input logic [1:0] pcs, input logic ill);
    return {pcw, pcwc, pcen, iord, mr, mw, irw, rd, mtr, rw, asa, asb, aop, pcs, ill};
  endfunction

  function automatic logic [19:0] observed();
    return {bus.PCWrite, bus.PCWriteCond, bus.PCEn, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.IRWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
            bus.ALUOP, bus.PCSource, bus.Illegal};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic push(input string tag, input logic [19:0] vec, input int cnt);
    entry_t e;
    e.tag = tag;
    e.vec = vec;
    e.cnt = cnt % (1 << COUNT_W);
    sb_q.push_back(e);
  endtask

  // Caller sits just after a rising edge; each entry is compared at the following falling edge.
  task automatic drain();
    entry_t e;
    while (sb_q.size() > 0) begin
      @(negedge clk);
      e = sb_q.pop_front();
      check_output({e.tag, "/ctrl"}, {12'd0, observed()}, {12'd0, e.vec});
      check_output({e.tag, "/cnt"}, {{(32-COUNT_W){1'b0}}, bus.InstrCount}, e.cnt);
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [19:0] v_fetch();
    return mk(1,0,1,0,1,0,1,2'b00,2'b00,0,0,2'b01,2'b00,2'b00,0);
  endfunction

  function automatic logic [19:0] v_rst();
    return mk(0,0,0,0,0,0,0,2'b00,2'b00,0,0,2'b01,2'b00,2'b00,0);
  endfunction

  task automatic apply_stimulus(input string name, input logic [5:0] op, input logic z);
    logic ill;
    ill = 1'b0;
    bus.Opcode = op;
    bus.Zero   = z;
    push({name, ".fetch"}, v_fetch(), exp_count);
    case (op)
      6'b100011: begin
        push({name, ".dec"},   mk(0,0,0,0,0,0,0,2'b00,2'b00,0,0,2'b11,2'b00,2'b00,0), exp_count);
        push({name, ".adr"},   mk(0,0,0,0,0,0,0,2'b00,2'b00,0,1,2'b10,2'b00,2'b00,0), exp_count);
        push({name, ".memrd"}, mk(0,0,0,1,1,0,0,2'b00,2'b00,0,0,2'b00,2'b00,2'b00,0), exp_count);
        push({name, ".memwb"}, mk(0,0,0,0,0,0,0,2'b00,2'b01,1,0,2'b00,2'b00,2'b00,0), exp_count);
      end
      6'b101011: begin
        push({name, ".dec"},   mk(0,0,0,0,0,0,0,2'b00,2'b00,0,0,2'b11,2'b00,2'b00,0), exp_count);
        push({name, ".adr"},   mk(0,0,0,0,0,0,0,2'b00,2'b00,0,1,2'b10,2'b00,2'b00,0), exp_count);
        push({name, ".memwr"}, mk(0,0,0,1,0,1,0,2'b00,2'b00,0,0,2'b00,2'b00,2'b00,0), exp_count);
      end
      6'b000000: begin
        push({name, ".dec"},   mk(0,0,0,0,0,0,0,2'b00,2'b00,0,0,2'b11,2'b00,2'b00,0), exp_count);
        push({name, ".rexec"}, mk(0,0,0,0,0,0,0,2'b00,2'b00,0,1,2'b00,2'b10,2'b00,0), exp_count);
        push({name, ".rwb"},   mk(0,0,0,0,0,0,0,2'b01,2'b00,1,0,2'b00,2'b00,2'b00,0), exp_count);
      end
      6'b001000, 6'b001010: begin
        push({name, ".dec"},   mk(0,0,0,0,0,0,0,2'b00,2'b00,0,0,2'b11,2'b00,2'b00,0), exp_count);
        push({name, ".iex"},   mk(0,0,0,0,0,0,0,2'b00,2'b00,0,1,2'b10,
                                  (op == 6'b001010) ? 2'b11 : 2'b00,2'b00,0), exp_count);
        push({name, ".iwb"},   mk(0,0,0,0,0,0,0,2'b00,2'b00,1,0,2'b00,2'b00,2'b00,0), exp_count);
      end
      6'b000100: begin
        push({name, ".dec"},   mk(0,0,0,0,0,0,0,2'b00,2'b00,0,0,2'b11,2'b00,2'b00,0), exp_count);
        push({name, ".beq"},   mk(0,1,z,0,0,0,0,2'b00,2'b00,0,1,2'b00,2'b01,2'b01,0), exp_count);
      end
      6'b000010: begin
        push({name, ".dec"},   mk(0,0,0,0,0,0,0,2'b00,2'b00,0,0,2'b11,2'b00,2'b00,0), exp_count);
        push({name, ".jump"},  mk(1,0,1,0,0,0,0,2'b00,2'b00,0,0,2'b00,2'b00,2'b10,0), exp_count);
      end
`ifdef MC_JAL_EN
      6'b000011: begin
        push({name, ".dec"},   mk(0,0,0,0,0,0,0,2'b00,2'b00,0,0,2'b11,2'b00,2'b00,0), exp_count);
        push({name, ".jal"},   mk(1,0,1,0,0,0,0,2'b10,2'b10,1,0,2'b00,2'b00,2'b10,0), exp_count);
      end
`endif
      default: ill = 1'b1;
    endcase
    if (ill)
      push({name, ".dec"}, mk(0,0,0,0,0,0,0,2'b00,2'b00,0,0,2'b11,2'b00,2'b00,1), exp_count);
    drain();
    exp_count++;
  endtask

  initial begin
    rst        = 1'b1;
    bus.Opcode = 6'b000000;
    bus.Zero   = 1'b0;
    @(posedge clk);
    #1;
    push("reset0", v_rst(), 0);
    push("reset1", v_rst(), 0);
    drain();
    rst = 1'b0;

    apply_stimulus("lw",      6'b100011, 1'b0);
    apply_stimulus("sw",      6'b101011, 1'b0);
    apply_stimulus("rtype",   6'b000000, 1'b1);
    apply_stimulus("addi",    6'b001000, 1'b0);
    apply_stimulus("slti",    6'b001010, 1'b0);
    apply_stimulus("beq_z1",  6'b000100, 1'b1);
    apply_stimulus("beq_z0",  6'b000100, 1'b0);
    apply_stimulus("j",       6'b000010, 1'b0);
    apply_stimulus("jal",     6'b000011, 1'b0);
    apply_stimulus("ill3f",   6'b111111, 1'b0);

    // Reset asserted during MEMRD of a lw and held across three edges.
    bus.Opcode = 6'b100011;
    push("mrst.fetch", v_fetch(), exp_count);
    push("mrst.dec", mk(0,0,0,0,0,0,0,2'b00,2'b00,0,0,2'b11,2'b00,2'b00,0), exp_count);
    push("mrst.adr", mk(0,0,0,0,0,0,0,2'b00,2'b00,0,1,2'b10,2'b00,2'b00,0), exp_count);
    drain();
    rst = 1'b1;
    push("mrst.memrd", mk(0,0,0,1,0,0,0,2'b00,2'b00,0,0,2'b00,2'b00,2'b00,0), exp_count);
    exp_count = 0;
    push("mrst.hold1", v_rst(), 0);
    push("mrst.hold2", v_rst(), 0);
    drain();
    rst = 1'b0;
    apply_stimulus("post_rst_sw", 6'b101011, 1'b0);

    // Counter wraps modulo 2^COUNT_W.
    for (int i = 0; i < 18; i++)
      apply_stimulus("wrap_j", 6'b000010, 1'b0);
    apply_stimulus("after_wrap_r", 6'b000000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
